// File: rtl/l1_port_arbiter_pkg.sv
// Shared types for the two-port L1 arbiter: FSM states, requester ids and the
// access-size encodings understood by both the CPU ports and the L1.
package l1_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef logic req_id_t;
  localparam req_id_t REQ_FETCH = 1'b0;
  localparam req_id_t REQ_DATA  = 1'b1;

  localparam logic [2:0] DTYPE_BYTE   = 3'd0;
  localparam logic [2:0] DTYPE_HALF   = 3'd1;
  localparam logic [2:0] DTYPE_WORD   = 3'd2;
  localparam logic [2:0] DTYPE_DOUBLE = 3'd3;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wr_data;
    logic [2:0]  dtype;
  } l1_req_t;

endpackage

// File: rtl/l1_arb_sat_counter.sv
// Saturating up-counter used to count accepted requests per requester port.
module l1_arb_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/l1_port_arbiter.sv
// Round-robin arbiter between the fetch (0) and data (1) CPU ports in front of
// a single-outstanding L1 request channel.
module l1_port_arbiter
  import l1_port_arbiter_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter bit RST_PTR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_valid,
  output logic             m0_ready,
  input  logic             m0_we,
  input  logic [63:0]      m0_addr,
  input  logic [63:0]      m0_wr_data,
  input  logic [2:0]       m0_dtype,
  output logic             m0_resp_valid,
  output logic [63:0]      m0_rd_data,
  input  logic             m1_valid,
  output logic             m1_ready,
  input  logic             m1_we,
  input  logic [63:0]      m1_addr,
  input  logic [63:0]      m1_wr_data,
  input  logic [2:0]       m1_dtype,
  output logic             m1_resp_valid,
  output logic [63:0]      m1_rd_data,
  output logic             cpu_to_l1__valid,
  output logic             cpu_to_l1__we,
  output logic [63:0]      cpu_to_l1__addr,
  output logic [63:0]      cpu_to_l1__wr_data,
  output logic [2:0]       cpu_to_l1__dtype,
  input  logic             cpu_to_l1__ready,
  input  logic [63:0]      cpu_to_l1__rd_data,
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt_0,
  output logic [CNT_W-1:0] grant_cnt_1
);

  arb_state_t  state;
  req_id_t     ptr;
  req_id_t     owner;
  l1_req_t     req_q;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        l1_valid_q;
  logic        busy_q;
  logic        resp0_q;
  logic        resp1_q;
  logic [63:0] rd0_q;
  logic [63:0] rd1_q;

  // ptr names the port that wins when both request together.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state == ST_IDLE) && !rst) begin
      if (m0_valid && m1_valid) begin
        grant1 = (ptr == REQ_DATA);
        grant0 = (ptr == REQ_FETCH);
      end else begin
        grant0 = m0_valid;
        grant1 = m1_valid;
      end
    end
  end

  assign accept = grant0 | grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= req_id_t'(RST_PTR);
      owner      <= REQ_FETCH;
      req_q      <= '0;
      l1_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      resp0_q    <= 1'b0;
      resp1_q    <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
    end else begin
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner      <= grant1 ? REQ_DATA : REQ_FETCH;
            ptr        <= grant1 ? REQ_FETCH : REQ_DATA;
            req_q      <= grant1 ? l1_req_t'{m1_we, m1_addr, m1_wr_data, m1_dtype}
                                 : l1_req_t'{m0_we, m0_addr, m0_wr_data, m0_dtype};
            l1_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cpu_to_l1__ready) begin
            l1_valid_q <= 1'b0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cpu_to_l1__ready) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
            if (owner == REQ_DATA) begin
              rd1_q   <= cpu_to_l1__rd_data;
              resp1_q <= 1'b1;
            end else begin
              rd0_q   <= cpu_to_l1__rd_data;
              resp0_q <= 1'b1;
            end
          end
        end
        default: begin
          l1_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_ready           = grant0;
  assign m1_ready           = grant1;
  assign m0_resp_valid      = resp0_q;
  assign m1_resp_valid      = resp1_q;
  assign m0_rd_data         = rd0_q;
  assign m1_rd_data         = rd1_q;
  assign cpu_to_l1__valid   = l1_valid_q;
  assign cpu_to_l1__we      = req_q.we;
  assign cpu_to_l1__addr    = req_q.addr;
  assign cpu_to_l1__wr_data = req_q.wr_data;
  assign cpu_to_l1__dtype   = req_q.dtype;
  assign busy               = busy_q;

  l1_arb_sat_counter #(.CNT_W(CNT_W)) u_cnt_0 (
    .clk (clk),
    .rst (rst),
    .inc (grant0),
    .cnt (grant_cnt_0)
  );

  l1_arb_sat_counter #(.CNT_W(CNT_W)) u_cnt_1 (
    .clk (clk),
    .rst (rst),
    .inc (grant1),
    .cnt (grant_cnt_1)
  );

endmodule

// File: doc/l1_port_arbiter.md
L1_PORT_ARBITER -- requirements
Module: l1_port_arbiter

Interface
REQ-001 Parameter CNT_W, default 16: width of each per-requester grant counter.
REQ-002 Parameter RST_PTR, default 1: requester favoured by round-robin after reset (1 = data port).
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 m<i>_valid  in  1  requester i (i=0 fetch, i=1 data) presents a request.
REQ-007 m<i>_ready  out  1  request i accepted this cycle.
REQ-008 m<i>_we / m<i>_addr / m<i>_wr_data / m<i>_dtype  in  1/64/64/3  request payload.
REQ-009 m<i>_resp_valid  out  1  one-cycle completion pulse to requester i.
REQ-010 m<i>_rd_data  out  64  read data, valid when m<i>_resp_valid=1.
REQ-011 cpu_to_l1__valid / __we / __addr / __wr_data / __dtype  out  1/1/64/64/3  downstream L1 request.
REQ-012 cpu_to_l1__ready  in  1  L1 accept/complete indication.
REQ-013 cpu_to_l1__rd_data  in  64  L1 read data.
REQ-014 busy  out  1  a transaction is owned (state != IDLE).
REQ-015 grant_cnt_0 / grant_cnt_1  out  CNT_W each  accepted-request counts.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT; one transaction in flight maximum.
REQ-017 IDLE: when any m<i>_valid=1, the winner's m<i>_ready SHALL assert combinationally that cycle; its payload and id latch; next state ISSUE.
REQ-018 Arbitration: single requester wins; both valid -> the requester not granted last wins; after reset the pointer favours RST_PTR.
REQ-019 m<i>_ready SHALL be 0 in ISSUE and WAIT; the loser SHALL hold valid and payload stable until accepted.
REQ-020 ISSUE: cpu_to_l1__valid=1 with latched payload; on cpu_to_l1__ready=1 go WAIT; otherwise stay in ISSUE.
REQ-021 WAIT: cpu_to_l1__valid=0; the first cycle with cpu_to_l1__ready=1 completes: rd_data latches, go IDLE.
REQ-022 The owner's m<i>_resp_valid SHALL pulse exactly one cycle, the cycle after completion, with m<i>_rd_data held until the next completion for that port.
REQ-023 Stores also produce m<i>_resp_valid; rd_data for stores is don't-care.
REQ-024 A new request SHALL be acceptable in the same cycle a resp_valid pulse is driven; minimum accept-to-accept spacing is 3 cycles.
REQ-025 Minimum latency: accept at cycle T, L1 valid at T+1, completion at T+2, resp_valid at T+3.
REQ-026 grant_cnt_i SHALL increment on each acceptance of requester i and saturate at all-ones.
REQ-027 cpu_to_l1__valid SHALL never assert in IDLE or WAIT; outputs are glitch-free from registered state.

Reset
REQ-028 Asserting rst SHALL, without a clock edge, force: state IDLE, cpu_to_l1__valid=0, all m<i>_ready=0, m<i>_resp_valid=0, m<i>_rd_data=0, busy=0, grant counters 0, pointer=RST_PTR.
REQ-029 Reset during ISSUE or WAIT SHALL abandon the transaction with no resp_valid; L1 is reset by the same rst.

Structure
REQ-030 Shared package SHALL hold the state enum, requester-id type, and DTYPE constants (byte/half/word/double encodings) used by the CPU and L1.
REQ-031 One sub-module, l1_arb_sat_counter (parameterised CNT_W saturating counter), SHALL be instantiated once per requester.

Verification
REQ-032 Only m0 valid, addr=0x10000, L1 ready at T+1 and T+2 -> m0_ready at T, L1 addr=0x10000 at T+1, m0_resp_valid at T+3, grant_cnt_0=1.
REQ-033 m0 and m1 valid together after reset -> m1 granted first, then m0; alternating over 4 grants to give counts 2/2.
REQ-034 L1 ready held low 5 cycles in ISSUE -> L1 valid and payload stable all 5 cycles, no m<i>_ready.
REQ-035 Store from m1, addr=0x2008, wr_data=0xDEADBEEF, dtype=3 -> L1 we=1 with those values; m1_resp_valid one cycle.
REQ-036 rst asserted mid-WAIT -> busy=0 and L1 valid=0 immediately, no resp_valid, counters 0.
REQ-037 Force grant_cnt_0 to 0xFFFF then one more m0 grant -> count stays 0xFFFF.
